// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory sequencer/arbiter.
// Protected-region constants are used when MEM_ARB_WRITE_PROTECT_EN is defined.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    // Top six address bits select the region: ROM is 6'b000000, GROM is 4'b0010xx.
    localparam logic [5:0] ROM_PREFIX  = 6'b000000;
    localparam logic [3:0] GROM_PREFIX = 4'b0010;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    function automatic logic is_protected(input logic [5:0] adr_hi);
        return (adr_hi == ROM_PREFIX) || (adr_hi[5:2] == GROM_PREFIX);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Two-input fixed-priority arbiter (port 0 first) with a saturating
// starvation counter that hands the grant to port 1 once it has waited too long.
module mem_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic arb_en,
    input  logic req0,
    input  logic req1,
    output logic gnt_vld,
    output logic gnt_idx
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == CW'(STARVE_MAX));

    always_comb begin
        gnt_vld = arb_en & (req0 | req1);
        gnt_idx = req1 & (~req0 | starved);
    end

    // Counter only moves on arbitration (IDLE) cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (gnt_vld && gnt_idx) begin
                starve_cnt <= '0;
            end else if (gnt_vld && req1 && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end else if (!req1) begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Two-port sequencer/arbiter driving the active-low SRAM-style memory bus.
// Optional write protection of ROM/GROM regions: define MEM_ARB_WRITE_PROTECT_EN.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int AW         = 18,
    parameter int DW         = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [1:0]    m0_be,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [1:0]    m1_be,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          prot_err,
    output logic          RAMCS,
    output logic          RAMOE,
    output logic          RAMWE,
    output logic          RAMLB,
    output logic          RAMUB,
    output logic [AW-1:0] ADR,
    output logic [DW-1:0] sram_dout,
    input  logic [DW-1:0] sram_din,
    output logic          busy
);

    localparam int         HW       = DW / 2;
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("mem_arb: RD_LAT out of range");
    end

    state_t        state, state_nxt;
    logic [1:0]    lat_cnt;
    logic          rd_last;
    logic          gnt_vld, gnt_idx, grant;
    logic          sel_we;
    logic [1:0]    sel_be;
    logic [AW-1:0] sel_adr;
    logic [DW-1:0] sel_wdata;
    logic          gnt_p1, we_p1;
    logic [1:0]    be_p1;
    logic [AW-1:0] adr_p1;
    logic [DW-1:0] wdata_p1;
    logic [DW-1:0] m0_rdata_p1, m1_rdata_p1;
    logic          wr_blk;

    mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk     (clk),
        .reset_n (reset_n),
        .arb_en  (state == ST_IDLE),
        .req0    (m0_req),
        .req1    (m1_req),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign grant = gnt_vld;

    always_comb begin
        sel_we    = m0_we;
        sel_be    = m0_be;
        sel_adr   = m0_adr;
        sel_wdata = m0_wdata;
        if (gnt_idx) begin
            sel_we    = m1_we;
            sel_be    = m1_be;
            sel_adr   = m1_adr;
            sel_wdata = m1_wdata;
        end
    end

`ifdef MEM_ARB_WRITE_PROTECT_EN
    logic prot_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prot_p1 <= 1'b0;
        end else if (grant) begin
            prot_p1 <= sel_we & is_protected(sel_adr[AW-1 -: 6]);
        end
    end

    assign wr_blk = prot_p1;
`else
    assign wr_blk = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes decode straight from state so an async reset releases them at once.
    always_comb begin
        state_nxt = state;
        rd_last   = 1'b0;
        RAMCS     = 1'b1;
        RAMOE     = 1'b1;
        RAMWE     = 1'b1;
        RAMLB     = 1'b1;
        RAMUB     = 1'b1;
        case (state)
            ST_IDLE:   if (grant) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = we_p1 ? ST_ACK : ST_RDWAIT;
            ST_RDWAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_nxt = ST_ACK;
                    rd_last   = 1'b1;
                end
            end
            ST_ACK:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (state == ST_ACCESS || state == ST_RDWAIT) begin
            RAMCS = wr_blk;
            RAMLB = ~be_p1[0];
            RAMUB = ~be_p1[1];
            if (!we_p1) begin
                RAMOE = 1'b0;
            end else if (state == ST_ACCESS) begin
                RAMWE = wr_blk;
            end
        end
    end

    // Stage p1: access fields latched at grant, held until the next grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt     <= 2'd0;
            gnt_p1      <= 1'b0;
            we_p1       <= 1'b0;
            be_p1       <= 2'b00;
            adr_p1      <= '0;
            wdata_p1    <= '0;
            m0_rdata_p1 <= '0;
            m1_rdata_p1 <= '0;
        end else begin
            if (state == ST_IDLE && grant) begin
                gnt_p1   <= gnt_idx;
                we_p1    <= sel_we;
                be_p1    <= sel_be;
                adr_p1   <= sel_adr;
                wdata_p1 <= sel_wdata;
            end
            if (state == ST_ACCESS) begin
                lat_cnt <= 2'd0;
            end else if (state == ST_RDWAIT) begin
                lat_cnt <= lat_cnt + 2'd1;
            end
            // Disabled lanes keep their previous contents.
            if (rd_last && !gnt_p1) begin
                if (be_p1[0]) m0_rdata_p1[HW-1:0]  <= sram_din[HW-1:0];
                if (be_p1[1]) m0_rdata_p1[DW-1:HW] <= sram_din[DW-1:HW];
            end
            if (rd_last && gnt_p1) begin
                if (be_p1[0]) m1_rdata_p1[HW-1:0]  <= sram_din[HW-1:0];
                if (be_p1[1]) m1_rdata_p1[DW-1:HW] <= sram_din[DW-1:HW];
            end
        end
    end

    assign ADR       = adr_p1;
    assign sram_dout = wdata_p1;
    assign m0_rdata  = m0_rdata_p1;
    assign m1_rdata  = m1_rdata_p1;
    assign m0_ack    = (state == ST_ACK) & ~gnt_p1;
    assign m1_ack    = (state == ST_ACK) &  gnt_p1;
    assign prot_err  = (state == ST_ACK) & wr_blk;
    assign busy      = (state != ST_IDLE);

endmodule
